frame_uart_sender: RTL and testbench

Streams a finished 320x240 7-bit filtered frame out of its frame-buffer BRAM over an 8N1 UART link when the photobooth enters its SEND state. It is the read-side client of the dither/wave/ridge frame buffers: it drives the BRAM port-B address, captures the registered read data, and serializes every pixel to the host. It also raises a lock that the top level uses to gate BRAM writes for the duration of the transfer.

---
 rtl/frame_uart_sender_if.sv | 33 +++
 rtl/frame_uart_sender.sv | 207 ++++++++++++++++++++
 tb/tb_frame_uart_sender.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_uart_sender_if.sv
// Bus bundle between the frame sender and its surroundings: start request,
// frame-buffer read port, UART line and status flags.
interface frame_uart_sender_if;
  logic        start_in;
  logic [16:0] addr_out;
  logic [6:0]  pixel_in;
  logic        tx_out;
  logic        busy_out;
  logic        frame_lock_out;
  logic        done_out;

  // Surroundings: issue start, serve BRAM data, observe the link.
  modport master (
    output start_in,
    output pixel_in,
    input  addr_out,
    input  tx_out,
    input  busy_out,
    input  frame_lock_out,
    input  done_out
  );

  // Sender side.
  modport slave (
    input  start_in,
    input  pixel_in,
    output addr_out,
    output tx_out,
    output busy_out,
    output frame_lock_out,
    output done_out
  );
endinterface

// File: rtl/frame_uart_sender.sv
// Streams a 7-bit frame from BRAM over an 8N1 UART: header 0x80, one byte
// per pixel in raster order, trailer 0x81. Pixel reads are prefetched into
// a one-entry holding register so bytes go out back-to-back.
module frame_uart_sender #(
  parameter int H_PIX        = 320,
  parameter int V_PIX        = 240,
  parameter int BAUD_DIV     = 564,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  frame_uart_sender_if.slave bus
);

  localparam int                N_PIX     = H_PIX * V_PIX;
  localparam int                BAUD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [16:0]       PIX_LAST  = 17'(N_PIX - 1);
  localparam logic [7:0]        HDR_BYTE  = 8'h80;
  localparam logic [7:0]        TRL_BYTE  = 8'h81;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PIXELS,
    S_TRAILER,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_start_p0;
  logic [BAUD_W-1:0]   r_baud_cnt;
  logic [3:0]          r_bit_idx;
  logic [7:0]          r_data;
  logic                r_tx;
  logic                r_cur_last;
  logic [16:0]         r_pix_cnt;
  logic [16:0]         r_addr;
  logic                r_fetch_done;
  logic [READ_LATENCY:0] r_rd_vld_p;
  logic [6:0]          r_hold;
  logic                r_hold_vld;
  logic                r_hold_last;

  logic                w_active;
  logic                w_bit_end;
  logic                w_byte_end;
  logic                w_start_acc;
  logic                w_load;
  logic                w_load_pix;
  logic                w_issue;
  logic                w_busy;
  logic                w_done;
  logic [7:0]          w_next_data;

  assign w_active   = (r_state == S_HEADER) || (r_state == S_PIXELS) ||
                      (r_state == S_TRAILER);
  assign w_bit_end  = (r_baud_cnt == BAUD_LAST);
  assign w_byte_end = w_active && w_bit_end && (r_bit_idx == 4'd9);
  // Only one read is ever outstanding, and only while the holding slot is free.
  assign w_issue    = ((r_state == S_HEADER) || (r_state == S_PIXELS)) &&
                      !r_hold_vld && !(|r_rd_vld_p) && !r_fetch_done;

  // Start request register; a request is only remembered while idle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) r_start_p0 <= 1'b0;
    else         r_start_p0 <= bus.start_in && (r_state == S_IDLE);
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state, byte sequencing and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_start_acc = 1'b0;
    w_load      = 1'b0;
    w_load_pix  = 1'b0;
    w_next_data = r_data;
    unique case (r_state)
      S_IDLE: begin
        if (r_start_p0) begin
          w_state_nxt = S_HEADER;
          w_start_acc = 1'b1;
          w_load      = 1'b1;
          w_next_data = HDR_BYTE;
        end
      end
      S_HEADER: begin
        w_busy = 1'b1;
        if (w_byte_end) begin
          w_state_nxt = S_PIXELS;
          w_load      = 1'b1;
          w_load_pix  = 1'b1;
          w_next_data = {1'b0, r_hold};
        end
      end
      S_PIXELS: begin
        w_busy = 1'b1;
        if (w_byte_end) begin
          w_load = 1'b1;
          if (r_cur_last) begin
            w_state_nxt = S_TRAILER;
            w_next_data = TRL_BYTE;
          end else begin
            w_load_pix  = 1'b1;
            w_next_data = {1'b0, r_hold};
          end
        end
      end
      S_TRAILER: begin
        w_busy = 1'b1;
        if (w_byte_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit serializer: start bit on load, data LSB first, then stop bit.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
    end else if (w_load) begin
      r_tx       <= 1'b0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
    end else if (w_active) begin
      if (w_bit_end) begin
        r_baud_cnt <= '0;
        if (r_bit_idx == 4'd9) begin
          r_tx      <= 1'b1;
          r_bit_idx <= '0;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= (r_bit_idx == 4'd8) ? 1'b1 : r_data[r_bit_idx[2:0]];
        end
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end else begin
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
    end
  end

  // Byte being shifted and captured pixel data (no reset needed).
  always_ff @(posedge clk_in) begin
    if (w_load) r_data <= w_next_data;
    if (r_rd_vld_p[READ_LATENCY]) r_hold <= bus.pixel_in;
  end

  // Prefetch control: address issue, read-latency tracking, holding slot.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_pix_cnt    <= '0;
      r_addr       <= '0;
      r_fetch_done <= 1'b0;
      r_rd_vld_p   <= '0;
      r_hold_vld   <= 1'b0;
      r_hold_last  <= 1'b0;
      r_cur_last   <= 1'b0;
    end else if (w_start_acc) begin
      r_pix_cnt    <= '0;
      r_fetch_done <= 1'b0;
      r_rd_vld_p   <= '0;
      r_hold_vld   <= 1'b0;
      r_hold_last  <= 1'b0;
      r_cur_last   <= 1'b0;
    end else begin
      r_rd_vld_p <= {r_rd_vld_p[READ_LATENCY-1:0], w_issue};
      if (w_issue) begin
        r_addr <= r_pix_cnt;
        if (r_pix_cnt == PIX_LAST) r_fetch_done <= 1'b1;
        else                       r_pix_cnt    <= r_pix_cnt + 17'd1;
      end
      // Reads return in order with one in flight, so the read that lands
      // after the final address was issued is the last pixel.
      if (r_rd_vld_p[READ_LATENCY]) begin
        r_hold_vld  <= 1'b1;
        r_hold_last <= r_fetch_done;
      end else if (w_load_pix) begin
        r_hold_vld  <= 1'b0;
      end
      if (w_load_pix) r_cur_last <= r_hold_last;
    end
  end

  assign bus.addr_out       = r_addr;
  assign bus.tx_out         = r_tx;
  assign bus.busy_out       = w_busy;
  assign bus.frame_lock_out = w_busy;
  assign bus.done_out       = w_done;

endmodule

// File: tb/tb_frame_uart_sender.sv
// Bench for frame_uart_sender on a 4x2 frame: UART decoder plus scoreboard
// of expected bytes, status monitor, and randomized frame contents/timing.
module tb_frame_uart_sender;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int BD = 4;
  localparam int RL = 2;
  localparam int N  = H * V;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_uart_sender_if bus ();

  frame_uart_sender #(
    .H_PIX(H), .V_PIX(V), .BAUD_DIV(BD), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(bus)
  );

  // BRAM model: data for the presented address appears RL cycles later.
  logic [6:0] mem  [N];
  logic [6:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= (bus.addr_out < 17'(N)) ? mem[bus.addr_out[2:0]] : 7'h00;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.pixel_in = pipe[RL-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard of bytes the host must receive.
  logic [7:0] exp_q [$];
  int  prev_fall    = -1;
  int  stream_start = -1;
  bit  abort        = 1'b0;

  // UART decoder: samples each bit mid-period and checks against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_out === 1'b0) begin : dec
        int fall;
        logic [7:0] d;
        logic sb, pb;
        fall  = cyc;
        abort = 1'b0;
        repeat (BD/2) @(negedge clk);
        sb = bus.tx_out;
        for (int b = 0; b < 8; b++) begin
          repeat (BD) @(negedge clk);
          d[b] = bus.tx_out;
        end
        repeat (BD) @(negedge clk);
        pb = bus.tx_out;
        repeat (BD - BD/2 - 1) @(negedge clk);
        if (!abort) begin
          check("start_bit", int'(sb), 0);
          check("stop_bit", int'(pb), 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte: got 0x%02h, expected no byte", d);
          end else begin
            check("byte", int'(d), int'(exp_q.pop_front()));
          end
          if (d == 8'h80) stream_start = fall;
          else            check("byte_spacing", fall - prev_fall, 10*BD);
          prev_fall = fall;
        end
      end
    end
  end

  // Status monitor: done pulses, frame length, lock, address sequence.
  int          done_cnt  = 0;
  int          lock_err  = 0;
  logic        prev_done = 1'b0;
  logic        prev_busy = 1'b0;
  logic        a_ok;
  logic [16:0] aseq [$];
  always @(negedge clk) begin
    if (bus.frame_lock_out !== bus.busy_out) lock_err++;
    if (rst_n) begin
      if (bus.busy_out && !prev_busy) aseq.delete();
      if (bus.busy_out && (aseq.size() == 0 || aseq[$] != bus.addr_out))
        aseq.push_back(bus.addr_out);
      if (bus.done_out) begin
        done_cnt++;
        check("done_width", int'(prev_done), 0);
        check("frame_cycles", cyc - stream_start, (N+2)*10*BD);
        check("frame_lock", lock_err, 0);
        while (aseq.size() > 0 && aseq[0] != 17'd0) void'(aseq.pop_front());
        a_ok = (aseq.size() == N);
        for (int i = 0; i < N; i++)
          if (i < aseq.size() && aseq[i] != 17'(i)) a_ok = 1'b0;
        check("addr_sequence", int'(a_ok), 1);
      end
    end
    prev_done = bus.done_out;
    prev_busy = bus.busy_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       mem[i] = 7'(i + 16);
        1:       mem[i] = 7'h7F;
        default: mem[i] = 7'($urandom_range(0, 127));
      endcase
    end
  endtask

  task automatic push_expected();
    exp_q.push_back(8'h80);
    for (int i = 0; i < N; i++) exp_q.push_back({1'b0, mem[i]});
    exp_q.push_back(8'h81);
  endtask

  // Pulse start and check the one-edge acceptance delay.
  task automatic pulse_start();
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    check("busy_before_accept", int'(bus.busy_out), 0);
    tick();
    check("busy_rise", int'(bus.busy_out), 1);
    check("tx_fall", int'(bus.tx_out), 0);
  endtask

  task automatic run_frame(input int mode, input bit poke);
    int d0, t, errs;
    fill_mem(mode);
    push_expected();
    d0 = done_cnt;
    pulse_start();
    if (poke) begin
      repeat ($urandom_range(3, 30)) tick();
      bus.start_in = 1'b1;
      tick();
      bus.start_in = 1'b0;
    end
    t = 0;
    while (!bus.done_out && t < 2000) begin
      tick();
      t++;
    end
    check("done_seen", int'(bus.done_out), 1);
    if (poke && bus.done_out) begin
      bus.start_in = 1'b1;
      tick();
      bus.start_in = 1'b0;
    end
    errs = 0;
    repeat (60) begin
      tick();
      if (bus.tx_out !== 1'b1 || bus.busy_out !== 1'b0) errs++;
    end
    check("idle_after_trailer", errs, 0);
    check("done_count", done_cnt - d0, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, d0;
    bus.start_in = 1'b0;
    fill_mem(0);

    // Reset values held for 5 cycles, then a quiet line with no start.
    rst_n = 1'b0;
    errs  = 0;
    repeat (5) begin
      tick();
      if (bus.tx_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) errs++;
    end
    check("reset_outputs", errs, 0);
    check("reset_addr", int'(bus.addr_out), 0);
    check("reset_lock", int'(bus.frame_lock_out), 0);
    rst_n = 1'b1;
    errs  = 0;
    repeat (1000) begin
      tick();
      if (bus.tx_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) errs++;
    end
    check("quiet_line", errs, 0);

    // Known pattern, then back-to-back repeat of the same frame.
    run_frame(0, 1'b0);
    repeat ($urandom_range(1, 20)) tick();
    run_frame(0, 1'b0);

    // All pixels at the 7-bit maximum.
    run_frame(1, 1'b0);

    // Start requests while busy and during the done cycle.
    run_frame(0, 1'b1);

    // Reset partway through pixel 3 (fifth byte on the line).
    fill_mem(2);
    push_expected();
    pulse_start();
    repeat (4*10*BD + 3*BD + 1) tick();
    abort = 1'b1;
    rst_n = 1'b0;
    tick();
    check("reset_mid_tx", int'(bus.tx_out), 1);
    check("reset_mid_busy", int'(bus.busy_out), 0);
    check("reset_mid_lock", int'(bus.frame_lock_out), 0);
    rst_n = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    repeat (100) tick();
    check("reset_no_done", done_cnt - d0, 0);
    run_frame(2, 1'b0);

    // Randomized frames with random gaps and stray start requests.
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 25)) tick();
      run_frame(2, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
